// File: rtl/subtractor_serial_dff_if.sv
// +----------------------------------------------------------------------+
// | subtractor_serial_dff_if: start/busy/done bundle for serial subtract |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface subtractor_serial_dff_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] din1;
   logic [WIDTH-1:0] din2;
   logic             bin;
   logic [WIDTH-1:0] dout;
   logic             bout;
   logic             busy;
   logic             done;

   modport master (
      output start, din1, din2, bin,
      input  dout, bout, busy, done
   );

   modport slave (
      input  start, din1, din2, bin,
      output dout, bout, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/subtractor_serial_dff.sv
// +----------------------------------------------------------------------+
// | subtractor_serial_dff: bit-serial din1-din2-bin, LSB first, reg outs |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module subtractor_serial_dff #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   subtractor_serial_dff_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   r_q, r_d;
   logic               br_q, br_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic               bout_q, bout_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               diff_bit;
   logic               br_next;
   logic [WIDTH-1:0]   r_next;

   // One full-subtractor cell evaluated on the current LSBs.
   always_comb begin
      diff_bit = a_q[0] ^ b_q[0] ^ br_q;
      br_next  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      r_next   = {diff_bit, r_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      bout_d  = bout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.din1;
               b_d     = bus.din2;
               br_d    = bus.bin;
               cnt_d   = '0;
               r_d     = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            r_d   = r_next;
            br_d  = br_next;
            cnt_d = cnt_q + CNT_W'(1);
            // Last bit: publish the assembled word together with its borrow.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               dout_d  = r_next;
               bout_d  = br_next;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         dout_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.dout = dout_q;
   assign bus.bout = bout_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_subtractor_serial_dff.sv
// +----------------------------------------------------------------------+
// | tb_subtractor_serial_dff: random + directed bench with result model  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_subtractor_serial_dff;

   localparam int WIDTH = 8;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   subtractor_serial_dff_if #(.WIDTH(WIDTH)) sub_if ();

   subtractor_serial_dff #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sub_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an accepted request yields its arithmetic result WIDTH edges later.
   logic [WIDTH-1:0] m_dout = '0;
   logic             m_bout = 1'b0;
   logic             m_busy = 1'b0;
   logic             m_done = 1'b0;
   int               m_left = 0;
   logic [WIDTH-1:0] m_res  = '0;
   logic             m_bor  = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_dout <= '0; m_bout <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
         m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_dout <= m_res; m_bout <= m_bor;
               m_done <= 1'b1;  m_busy <= 1'b0;
            end
         end else if (sub_if.start) begin
            m_res  <= WIDTH'(int'(sub_if.din1) - int'(sub_if.din2) - int'(sub_if.bin));
            m_bor  <= (int'(sub_if.din1) < int'(sub_if.din2) + int'(sub_if.bin));
            m_left <= WIDTH;
            m_busy <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst)
         chk("cycle_outputs", {sub_if.dout, sub_if.bout, sub_if.busy, sub_if.done},
             {m_dout, m_bout, m_busy, m_done});
   end

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] exp_d, input logic exp_b, input int inj);
      int n;
      bit seen;
      sub_if.start = 1'b1; sub_if.din1 = a; sub_if.din2 = b; sub_if.bin = bi;
      @(negedge clk);
      chk("busy_after_accept", sub_if.busy, 1);
      chk("done_low_after_accept", sub_if.done, 0);
      seen = 0;
      for (n = 1; n <= 20; n++) begin
         sub_if.din1 = 8'($urandom); sub_if.din2 = 8'($urandom); sub_if.bin = 1'($urandom);
         sub_if.start = (n == inj);
         @(negedge clk);
         if (sub_if.done) begin
            seen = 1;
            break;
         end
      end
      sub_if.start = 1'b0;
      chk("done_seen", seen, 1);
      chk("latency", n, WIDTH);
      chk("dout", sub_if.dout, exp_d);
      chk("bout", sub_if.bout, exp_b);
      chk("busy_at_done", sub_if.busy, 0);
   endtask

   task automatic idle_no_done(input int cycles);
      int cnt;
      cnt = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (sub_if.done) cnt++;
      end
      chk("no_extra_done", cnt, 0);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rbi;
      int         v;

      rst = 1'b1;
      sub_if.start = 1'b0; sub_if.din1 = '0; sub_if.din2 = '0; sub_if.bin = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("reset_idle", {sub_if.dout, sub_if.bout, sub_if.busy, sub_if.done}, 0);
      end

      // Main function and borrow corners.
      run_op(8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 0);
      idle_no_done(2);
      run_op(8'd200, 8'd100, 1'b1, 8'd99,  1'b0, 0);
      run_op(8'd5,   8'd10,  1'b0, 8'd251, 1'b1, 0);
      run_op(8'd0,   8'd0,   1'b1, 8'd255, 1'b1, 0);
      run_op(8'd255, 8'd255, 1'b1, 8'd255, 1'b1, 0);
      run_op(8'd255, 8'd0,   1'b0, 8'd255, 1'b0, 0);
      idle_no_done(1);

      // Start during an operation is ignored.
      run_op(8'd77, 8'd12, 1'b0, 8'd65, 1'b0, 3);
      idle_no_done(10);

      // Back-to-back: second start issued while done is high.
      run_op(8'd40, 8'd41, 1'b0, 8'd255, 1'b1, 0);
      run_op(8'd50, 8'd20, 1'b0, 8'd30,  1'b0, 0);
      idle_no_done(2);

      // Reset mid-operation aborts.
      sub_if.start = 1'b1; sub_if.din1 = 8'd9; sub_if.din2 = 8'd3; sub_if.bin = 1'b0;
      @(negedge clk);
      sub_if.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("abort_outputs", {sub_if.dout, sub_if.bout, sub_if.busy, sub_if.done}, 0);
      @(negedge clk);
      rst = 1'b0;
      idle_no_done(10);
      chk("post_abort_dout", sub_if.dout, 0);
      run_op(8'd9, 8'd3, 1'b0, 8'd6, 1'b0, 0);

      // Random operations with occasional interfering starts and gaps.
      for (int k = 0; k < 60; k++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rbi = 1'($urandom);
         v   = int'(ra) - int'(rb) - int'(rbi);
         run_op(ra, rb, rbi, 8'(v), v < 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      idle_no_done(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/subtractor_serial_dff.md
Name: subtractor_serial_dff

Overview:
Bit-serial 8-bit subtractor with borrow-in and registered outputs. It computes dout = din1 - din2 - bin, one bit per clock, LSB first, and reports borrow-out. It is the inverse-operation companion to the team's registered parallel adder. It trades latency for area in datapaths where operand rate is low, and uses a start/busy/done handshake so upstream logic knows when a result is valid.

Parameters:
WIDTH, 8, operand/result width in bits; counter sized ceil(log2(WIDTH+1)).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when idle
din1  input  WIDTH  minuend, captured on accepted start
din2  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
dout  output  WIDTH  registered difference, holds last result
bout  output  1  registered borrow-out, holds last result
busy  output  1  registered; high while a subtraction is in progress
done  output  1  registered one-cycle pulse; result just updated

Behaviour:
- Reset (async, any time): state=IDLE, dout=0, bout=0, busy=0, done=0, shift regs/counter/borrow=0.
- FSM states: IDLE, SHIFT.
- IDLE: at the rising edge where start=1 (edge E0):
  - load A<=din1, B<=din2, br<=bin, cnt<=0, R<=0
  - busy<=1, done<=0, go to SHIFT.
  - If start=0: stay in IDLE, done<=0.
- SHIFT, edges E1..E(WIDTH), one bit per edge:
  - d = A[0]^B[0]^br
  - br <= (~A[0]&B[0]) | (~(A[0]^B[0])&br)
  - R shifts right with d entering at MSB; A and B shift right; cnt++.
- At edge E(WIDTH), when cnt reaches WIDTH-1 before the edge:
  - dout<=final R including this bit, bout<=final br
  - done<=1, busy<=0, go to IDLE.
- Latency: result and done appear WIDTH edges after the start-accept edge.
- done is high for exactly the one cycle after E(WIDTH) and clears at the next edge. Throughput is one operation per WIDTH+1 cycles minimum.
- Arithmetic: dout = (din1 - din2 - bin) mod 2^WIDTH. bout = 1 iff din1 < din2 + bin, unsigned.
- start while busy=1 is ignored, with no queueing and no error.
- start at the edge after done (state IDLE) is accepted. done still drops at that edge.
- din1/din2/bin changes after E0 have no effect on the operation in flight.
- dout/bout change only at a completion edge or at reset. Between operations they hold the last result.
- Reset mid-operation aborts: no done pulse, outputs go to 0, the next start behaves normally.
- No combinational path from inputs to outputs; all outputs come straight from flops.

Test Plan:
1. rst pulse, then idle 3 cycles -> dout=0, bout=0, busy=0, done=0 throughout.
2. start with din1=100, din2=37, bin=0 -> busy high for 8 cycles, done pulses once exactly 8 edges after accept, dout=63, bout=0. Repeat with 200-100-1 -> dout=99, bout=0.
3. Borrow cases:
   - 5-10-0 -> dout=251, bout=1
   - 0-0-1 -> dout=255, bout=1
   - 255-255-1 -> dout=255, bout=1
   - 255-0-0 -> dout=255, bout=0
4. start=1 with new operands at E3 of an operation, and din1/din2 toggled after E0 -> result matches the originally captured operands, no second done.
5. Back-to-back: second start (50-20-0) asserted in the cycle done=1 -> accepted, done drops next edge, second done 8 edges later with dout=30, bout=0.
6. Assert rst at E4 of 9-3-0 -> outputs 0, busy=0, no done. Release rst, start 9-3-0 -> dout=6, bout=0 after 8 edges.
